// File: rtl/alu_result_fifo_if.sv
// rtl/alu_result_fifo_if.sv - producer/consumer handshake bundle for alu_result_fifo
interface alu_result_fifo_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  // master: the surrounding pipeline (mux producer plus writeback consumer)
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - FWFT result buffer behind the operand/result mux
// Optional sticky overflow/underflow flags: ALU_RESULT_FIFO_ERR_EN
module alu_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  alu_result_fifo_if.slave     bus,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
`ifdef ALU_RESULT_FIFO_ERR_EN
  output logic                 empty,
  output logic                 err_ovf,
  output logic                 err_unf
`else
  output logic                 empty
`endif
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign full          = (count == CNT_W'(DEPTH));
  assign empty         = (count == '0);
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  // Head word is masked to zero while empty so stale memory never shows.
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left uncleared by reset/flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= bus.in_data;
  end

`ifdef ALU_RESULT_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (bus.in_valid && full)   err_ovf <= 1'b1;
      if (bus.out_ready && empty) err_unf <= 1'b1;
    end
  end
`endif
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Result buffer directly downstream of the 16-bit 2:1 operand/result mux.
- Captures each selected 16-bit word under a valid/ready handshake and holds it in a small first-word-fall-through FIFO.
- The consumer (writeback / display stage) drains the FIFO at its own pace, so the mux can produce results while the consumer is stalled.

Parameters:
- WIDTH, 16, data word width; matches the mux output.
- DEPTH, 4, number of entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of FIFO contents; keeps any configuration.
- in_data  input  WIDTH  word from the mux output.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_data  output  WIDTH  head-of-FIFO word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer takes out_data this cycle.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - write pointer = 0, read pointer = 0, count = 0.
  - Outputs: empty=1, full=0, out_valid=0, in_ready=1, out_data=0.
  - Memory contents are not cleared.
  - rst overrides flush, push and pop in the same cycle.
- Flush (flush=1, rst=0):
  - Same pointer/count effect as reset on the next edge.
  - Any push or pop in the same cycle is discarded.
- Handshake and derived outputs:
  - in_ready = !full. This is combinational from count and has no dependency on out_ready; there is no pass-through when full.
  - push = in_valid & in_ready. Writes mem[wr_ptr] and advances wr_ptr by 1.
  - out_valid = !empty.
  - pop = out_valid & out_ready. Advances rd_ptr by 1.
- Pointers and count:
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count: push only → +1; pop only → -1; push and pop together → unchanged.
- FWFT output:
  - out_data = mem[rd_ptr] when out_valid=1; forced to 0 when empty.
  - Latency: a word pushed at edge N is visible on out_data with out_valid=1 after edge N.
  - There is no same-cycle in→out bypass.
- Boundaries:
  - Empty with push and out_ready=1: only the push occurs, count becomes 1.
  - Full with in_valid=1: no write (in_ready=0). A pop in the same cycle still occurs, and in_ready rises the next cycle.
  - Full with pop and in_valid=1: pop only, count becomes DEPTH-1.
  - Order is strictly preserved across pointer wrap-around.
  - Producer side: in_data/in_valid may change freely while in_ready=0; the FIFO ignores them.
  - Consumer side: out_data is stable while out_valid=1 and out_ready=0.
- Control inputs must never be X after reset; the verification bench checks this.

Optional Feature:
- Macro: ALU_RESULT_FIFO_ERR_EN
- Defined:
  - Adds output `err_ovf` (1 bit) and output `err_unf` (1 bit), both sticky.
  - err_ovf sets on any cycle with in_valid=1 and full=1.
  - err_unf sets on any cycle with out_ready=1 and empty=1.
  - Both are cleared only by rst or flush, and reset to 0.
  - They do not affect the data path.
- Not defined: these ports and their logic do not exist. Producer and consumer must honour the handshake; there is no detection.

Test Plan:
- Basic order: after reset, push 0x0000, 0xFFFF, 0x00FF, 0xFF00 with out_ready=0 → count=4, full=1, in_ready=0. Then set out_ready=1 → out_data sequence 0x0000, 0xFFFF, 0x00FF, 0xFF00 over 4 cycles, then empty=1 and out_data=0.
- Simultaneous push/pop: with count=2 (0x1111, 0x2222), push 0x3333 with out_ready=1 → count stays 2 and the head becomes 0x2222. Drain → 0x2222, 0x3333.
- Full stall: at count=4, hold in_valid=1 with in_data=0xAAAA and out_ready=0 for 3 cycles → no write, count=4. One pop → in_ready=1 the next cycle, and 0xAAAA is accepted as the last entry.
- Wrap-around: stream 10 words 0x0001..0x000A with in_valid and out_ready both held at 1 → out_data shows exactly 0x0001..0x000A in order, with one cycle of latency, and count never exceeds 1.
- Flush/reset mid-operation: at count=3, assert flush together with in_valid → count=0, empty=1, out_valid=0 the next cycle, and the flushed-cycle push is lost. Repeat with rst=1 and flush=0 → same result.
- With ALU_RESULT_FIFO_ERR_EN: push 5 words into DEPTH=4 → err_ovf=1 from the 5th attempt on. Then drain 4 words and assert out_ready once more → err_unf=1. Then flush → both 0.
